// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues one outstanding imem request at a time,
// buffers returned instructions in an output register plus one skid entry,
// and hands them to decode over a valid/ready handshake. A flush kills the
// buffered instructions and turns an in-flight fetch into a dropped one.
module if_fetch #(
    parameter int AW = 32,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] fetch_pc,
    input  logic          flush,
    output logic          pc_adv,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [IW-1:0] id_inst,
    output logic          id_misalign,
    input  logic          id_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] infl_pc_q;
    logic          infl_mis_q;

    // Output register and skid entry, with their next-state values
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_pc_q,    out_pc_d;
    logic [IW-1:0] out_inst_q,  out_inst_d;
    logic          out_mis_q,   out_mis_d;
    logic          skid_valid_q, skid_valid_d;
    logic [AW-1:0] skid_pc_q,    skid_pc_d;
    logic [IW-1:0] skid_inst_q,  skid_inst_d;
    logic          skid_mis_q,   skid_mis_d;

    logic          accept_s;
    logic          consume_s;
    logic [IW-1:0] new_inst_s;

    assign imem_addr   = {fetch_pc[AW-1:2], 2'b00};
    assign id_valid    = out_valid_q;
    assign id_pc       = out_pc_q;
    assign id_inst     = out_inst_q;
    assign id_misalign = out_mis_q;

    // Request is blocked during reset, flush, outside REQ, or while the skid holds data
    always_comb begin
        imem_req = 1'b0;
        if (!rst && (state_q == S_REQ) && !flush && !skid_valid_q) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
        pc_adv = imem_req & imem_gnt;
    end

    // Response acceptance, decode consumption and the instruction value to store
    always_comb begin
        accept_s   = (state_q == S_WAIT) & imem_rvalid & ~flush;
        consume_s  = out_valid_q & id_ready;
        new_inst_s = infl_mis_q ? {IW{1'b0}} : imem_rdata;
    end

    // Output/skid routing: skid always drains to the output before new data lands
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        out_mis_d    = out_mis_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        skid_mis_d   = skid_mis_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume_s) begin
            if (skid_valid_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = skid_pc_q;
                out_inst_d  = skid_inst_q;
                out_mis_d   = skid_mis_q;
                if (accept_s) begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = infl_pc_q;
                    skid_inst_d  = new_inst_s;
                    skid_mis_d   = infl_mis_q;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else begin
                if (accept_s) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = infl_pc_q;
                    out_inst_d  = new_inst_s;
                    out_mis_d   = infl_mis_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end else if (accept_s) begin
            if (out_valid_q) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = infl_pc_q;
                skid_inst_d  = new_inst_s;
                skid_mis_d   = infl_mis_q;
            end else begin
                out_valid_d = 1'b1;
                out_pc_d    = infl_pc_q;
                out_inst_d  = new_inst_s;
                out_mis_d   = infl_mis_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Fetch FSM: grant captures the in-flight PC, response (or flush) leaves WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            infl_pc_q  <= {AW{1'b0}};
            infl_mis_q <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (pc_adv) begin
                        infl_pc_q  <= fetch_pc;
                        infl_mis_q <= |fetch_pc[1:0];
                        state_q    <= S_WAIT;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end else if (flush) begin
                        state_q <= S_DROP;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end else begin
                        state_q <= S_DROP;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= {AW{1'b0}};
            out_inst_q   <= {IW{1'b0}};
            out_mis_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= {AW{1'b0}};
            skid_inst_q  <= {IW{1'b0}};
            skid_mis_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            out_mis_q    <= out_mis_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            skid_mis_q   <= skid_mis_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed stimulus, a queue-based reference model
// checked every cycle, and hand-computed literal checks at key points.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        pc_adv;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misalign;
    logic        id_ready;

    int n_pass = 0;
    int n_tot  = 0;

    if_fetch #(.AW(32), .IW(32)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .flush(flush),
        .pc_adv(pc_adv), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_misalign(id_misalign), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } ent_t;

    // Reference model: instructions awaiting decode, in order (at most two)
    ent_t        m_q[$];
    bit          m_out  = 1'b0;   // a fetch is outstanding at memory
    bit          m_drop = 1'b0;   // outstanding fetch was killed by flush
    logic [31:0] m_pc   = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return !rst && !m_out && !flush && (m_q.size() < 2);
    endfunction

    // Model update on each rising edge from the inputs seen at that edge
    initial begin
        bit   req_now;
        ent_t e;
        forever begin
            @(posedge clk);
            req_now = exp_req();
            if (rst) begin
                m_q.delete();
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (flush) begin
                m_q.delete();
                if (m_out && imem_rvalid) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else if (m_out) begin
                    m_drop = 1'b1;
                end
            end else begin
                if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
                if (m_out && imem_rvalid) begin
                    if (!m_drop) begin
                        e.pc   = m_pc;
                        e.mis  = (m_pc[1:0] != 2'b00);
                        e.inst = e.mis ? 32'h0 : imem_rdata;
                        m_q.push_back(e);
                    end
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else if (req_now && imem_gnt) begin
                    m_out = 1'b1;
                    m_pc  = fetch_pc;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        bit er;
        forever begin
            @(negedge clk);
            er = exp_req();
            chk("imem_req", imem_req, er);
            chk("pc_adv", pc_adv, er & imem_gnt);
            chk("imem_addr", imem_addr, fetch_pc & 32'hFFFF_FFFC);
            chk("id_valid", id_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("id_pc", id_pc, m_q[0].pc);
                chk("id_inst", id_inst, m_q[0].inst);
                chk("id_misalign", id_misalign, m_q[0].mis);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; fetch_pc = 32'h0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        settle();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_mis", id_misalign, 1'b0);
        step();
        rst = 1'b0;

        // basic fetch: grant, response next cycle, presented the cycle after
        fetch_pc = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1;
        settle(); chk("t1_pc_adv", pc_adv, 1'b1);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        settle(); chk("t1_wait_req", imem_req, 1'b0);
        step();
        imem_rvalid = 1'b0;
        settle();
        chk("t1_valid", id_valid, 1'b1);
        chk("t1_pc", id_pc, 32'h0);
        chk("t1_inst", id_inst, 32'h0000_0013);
        step();

        // decode stalled: second response lands in skid, requests stop
        id_ready = 1'b0; fetch_pc = 32'h100; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_AAAA;
        step();
        imem_rvalid = 1'b0; fetch_pc = 32'h104; imem_gnt = 1'b1;
        settle(); chk("t2_adv2", pc_adv, 1'b1);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_BBBB;
        step();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; fetch_pc = 32'h108;
        settle();
        chk("t2_blk_req", imem_req, 1'b0);
        chk("t2_hold_inst", id_inst, 32'hAAAA_AAAA);
        step();
        settle();
        chk("t2_blk_req2", imem_req, 1'b0);
        chk("t2_hold_valid", id_valid, 1'b1);
        step();
        id_ready = 1'b1; imem_gnt = 1'b0;
        settle(); chk("t2_first", id_inst, 32'hAAAA_AAAA);
        step();
        settle();
        chk("t2_second", id_inst, 32'hBBBB_BBBB);
        chk("t2_second_pc", id_pc, 32'h104);
        chk("t2_resume", imem_req, 1'b1);
        step();
        settle(); chk("t2_empty", id_valid, 1'b0);

        // flush during WAIT: late response is dropped
        fetch_pc = 32'h200; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; flush = 1'b1;
        settle(); chk("t3_flush_req", imem_req, 1'b0);
        step();
        flush = 1'b0; fetch_pc = 32'h300; imem_gnt = 1'b1;
        settle(); chk("t3_drop_req", imem_req, 1'b0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        settle(); chk("t3_drop_adv", pc_adv, 1'b0);
        step();
        imem_rvalid = 1'b0;
        settle();
        chk("t3_new_adv", pc_adv, 1'b1);
        chk("t3_new_addr", imem_addr, 32'h300);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0333;
        step();
        imem_rvalid = 1'b0; id_ready = 1'b0; fetch_pc = 32'h400; imem_gnt = 1'b1;
        settle();
        chk("t3_valid", id_valid, 1'b1);
        chk("t3_pc", id_pc, 32'h300);
        chk("t3_inst", id_inst, 32'h0000_0333);
        step();

        // flush with response arriving and output full: both dropped
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0444; flush = 1'b1;
        settle(); chk("t4_flush_req", imem_req, 1'b0);
        step();
        imem_rvalid = 1'b0; flush = 1'b0;
        settle();
        chk("t4_valid", id_valid, 1'b0);
        chk("t4_req", imem_req, 1'b1);
        step();

        // misaligned fetch
        fetch_pc = 32'h102; imem_gnt = 1'b1; id_ready = 1'b1;
        settle(); chk("t5_addr", imem_addr, 32'h100);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_rvalid = 1'b0; id_ready = 1'b0; fetch_pc = 32'h500; imem_gnt = 1'b1;
        settle();
        chk("t5_valid", id_valid, 1'b1);
        chk("t5_mis", id_misalign, 1'b1);
        chk("t5_inst", id_inst, 32'h0);
        chk("t5_pc", id_pc, 32'h102);
        step();

        // reset while WAIT with a full output
        imem_gnt = 1'b0; rst = 1'b1;
        step();
        settle();
        chk("t6_valid", id_valid, 1'b0);
        chk("t6_req", imem_req, 1'b0);
        chk("t6_pc", id_pc, 32'h0);
        chk("t6_mis", id_misalign, 1'b0);
        step();
        rst = 1'b0; id_ready = 1'b1;
        settle(); chk("t6_req_again", imem_req, 1'b1);
        step();

        // stray response in REQ is ignored
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0777;
        step();
        imem_rvalid = 1'b0;
        settle(); chk("t7_stray", id_valid, 1'b0);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly downstream of the PC register.
- Takes the current fetch PC and issues single-outstanding requests to instruction memory using a req/gnt + rvalid handshake.
- Buffers returned instructions (output register plus one skid entry) and presents them to decode with a valid/ready handshake.
- Pulses pc_adv when a fetch is granted so the PC stage may advance; on flush it kills buffered and in-flight fetches.

Parameters:
- AW, 32, address/PC width in bits.
- IW, 32, instruction width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_pc  in  AW  PC to fetch, from the PC stage.
- flush  in  1  redirect; kills all buffered and in-flight fetches this cycle.
- pc_adv  out  1  one-cycle pulse: fetch_pc was accepted (imem_req & imem_gnt).
- imem_req  out  1  request to instruction memory.
- imem_addr  out  AW  word-aligned address, {fetch_pc[AW-1:2],2'b00}.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  IW  read data.
- id_valid  out  1  instruction available to decode.
- id_pc  out  AW  PC of the presented instruction.
- id_inst  out  IW  presented instruction.
- id_misalign  out  1  presented PC had fetch_pc[1:0] != 0; id_inst is forced to 0.
- id_ready  in  1  decode accepts the presented instruction this cycle.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - state=REQ; id_valid=0, id_pc=0, id_inst=0, id_misalign=0; skid empty.
  - pc_adv=0, imem_req=0 during the reset cycle.
- FSM states:
  - REQ: imem_req = !flush & !skid_full.
    - On imem_req & imem_gnt: capture fetch_pc and its misalign bit into infl_pc/infl_mis, pulse pc_adv, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, route the response (see buffering) and go to REQ.
  - DROP: imem_req=0. On imem_rvalid, discard the data and go to REQ.
- Outstanding requests: at most one. A new request may be granted in the same cycle WAIT returns to REQ only on the following cycle, so back-to-back throughput is one instruction per 2 cycles when rvalid arrives at grant+1.
- Latency: grant at cycle N, earliest rvalid at N+1, id_valid=1 at N+2 (output is registered).
- Output buffering:
  - An accepted response goes to the output register if it is empty or being consumed (id_valid & id_ready); otherwise it goes to the skid.
  - When the output is consumed and the skid is full, the skid moves to the output the same edge; a concurrent rvalid then goes to the skid.
  - Ordering is strictly preserved: skid before new data.
  - New requests are blocked while the skid is full, so the skid can never overflow.
- id_valid is held high with stable id_pc/id_inst/id_misalign until id_ready.
- Flush (highest priority after rst):
  - Next cycle: id_valid=0, skid empty.
  - If in WAIT with no rvalid this cycle, go to DROP.
  - If rvalid in the same cycle, the data is discarded and the FSM goes to REQ.
  - No request is issued in the flush cycle; pc_adv=0.
  - Flush while in DROP stays in DROP.
- Stray imem_rvalid in REQ is ignored.
- Reset asserted mid-transaction abandons the transaction. Instruction memory shares rst, so no response follows.
- Misalign: the request is still issued (word-aligned address). On response, id_misalign=1 and id_inst=0.

Test Plan:
- Reset then fetch_pc=0x0000_0000, gnt=1 at cycle 1, rvalid at cycle 2 with rdata=0x0000_0013 -> pc_adv pulse at cycle 1; id_valid=1, id_pc=0, id_inst=0x13 at cycle 3.
- id_ready=0 held, two fetches (0x100→0xAAAA_AAAA, 0x104→0xBBBB_BBBB) -> second lands in skid; imem_req stays 0. Raise id_ready -> 0xAAAA_AAAA then 0xBBBB_BBBB on consecutive cycles, then requests resume.
- Flush during WAIT (rvalid two cycles later, rdata=0xDEAD_BEEF) -> FSM goes to DROP; 0xDEAD_BEEF is never presented; next grant fetches the new fetch_pc.
- Flush with rvalid in the same cycle and the output full -> id_valid=0 next cycle; both the output and the arriving data are dropped.
- fetch_pc=0x0000_0102 -> imem_addr=0x0000_0100; id_misalign=1, id_inst=0, id_pc=0x102.
- Assert rst while in WAIT -> next cycle id_valid=0, imem_req=0, state REQ; the following cycle imem_req=1 again.
